// File: rtl/game_status_pkg.sv
// Shared game types for the game-status PIO link: event bit map,
// the gameStatus word layout and the queued entry format.
package game_status_pkg;

    localparam int EV_KILL0      = 0;
    localparam int EV_KILL1      = 1;
    localparam int EV_WALL0      = 2;
    localparam int EV_WALL1      = 3;
    localparam int EV_BULLET     = 4;
    localparam int EV_SPAWN0     = 5;
    localparam int EV_SPAWN1     = 6;
    localparam int EV_ROUND_OVER = 7;

    localparam int EVENT_W = 8;
    localparam int FRAME_W = 14;
    localparam int SCORE_W = 4;

    typedef struct packed {
        logic               valid;
        logic               overflow;
        logic [FRAME_W-1:0] frame_num;
        logic [EVENT_W-1:0] events;
        logic [SCORE_W-1:0] score1;
        logic [SCORE_W-1:0] score0;
    } status_word_t;

    typedef struct packed {
        logic [FRAME_W-1:0] frame_num;
        logic [EVENT_W-1:0] events;
    } status_entry_t;

endpackage

// File: rtl/status_fifo.sv
// Synchronous FIFO with async active-high reset. The head entry is visible
// combinationally. When full, a pop in the same cycle frees the slot so the
// push is still accepted.
module status_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic                     pop_ok,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok_s;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_COUNT);
    assign pop_ok    = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok);
    assign rdata     = mem_q[rd_ptr_q];
    assign count     = count_q;

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/game_status_reporter.sv
// Hardware-to-software game status path: gathers per-frame game events,
// keeps per-tank scores, detects round over and queues one entry per
// eventful frame for software to read through the gameStatus PIO.
module game_status_reporter
    import game_status_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int WIN_SCORE  = 5
) (
    input  logic                          sysClk,
    input  logic                          reset_h,
    input  logic                          frameClk,
    input  logic [1:0]                    tankKill,
    input  logic [1:0]                    tankExists,
    input  logic [1:0]                    bulletHitWall,
    input  logic                          bulletHitBullet,
    input  logic                          gameAck,
    input  logic                          clearScores,
    output logic [31:0]                   gameStatus,
    output logic                          roundOver,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

    localparam logic [SCORE_W-1:0] WIN_S = SCORE_W'(WIN_SCORE);

    // Input history flops for edge detection
    logic [1:0] kill_q, kill_d;
    logic [1:0] exists_q, exists_d;
    logic [1:0] wall_q, wall_d;
    logic       bb_q, bb_d;
    logic       ack_q, ack_d;
    logic       clear_q, clear_d;
    // frameClk synchronizer plus history
    logic       fsync1_q, fsync1_d;
    logic       fsync2_q, fsync2_d;
    logic       fsync3_q, fsync3_d;
    // Game state
    logic [EVENT_W-1:0] acc_q, acc_d;
    logic [FRAME_W-1:0] frame_num_q, frame_num_d;
    logic [SCORE_W-1:0] score0_q, score0_d;
    logic [SCORE_W-1:0] score1_q, score1_d;
    logic               round_over_q, round_over_d;
    logic               overflow_q, overflow_d;
    status_word_t       status_q, status_d;

    logic [EVENT_W-1:0] cur_ev_s;
    logic [EVENT_W-1:0] snap_s;
    logic               frame_edge_s;
    logic               ack_edge_s;
    logic               clear_edge_s;
    logic               push_s;
    status_entry_t      push_entry_s;
    status_entry_t      head_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               fifo_pop_ok_s;

    assign frame_edge_s = fsync2_q & ~fsync3_q;
    assign ack_edge_s   = gameAck & ~ack_q;
    assign clear_edge_s = clearScores & ~clear_q;

    // Sampling of levels into history and synchronizer flops
    always_comb begin
        kill_d   = tankKill;
        exists_d = tankExists;
        wall_d   = bulletHitWall;
        bb_d     = bulletHitBullet;
        ack_d    = gameAck;
        clear_d  = clearScores;
        fsync1_d = frameClk;
        fsync2_d = fsync1_q;
        fsync3_d = fsync2_q;
    end

    // Event accumulation, frame snapshot, scoring and overflow tracking
    always_comb begin
        cur_ev_s                = '0;
        cur_ev_s[EV_KILL0]      = tankKill[0] & ~kill_q[0];
        cur_ev_s[EV_KILL1]      = tankKill[1] & ~kill_q[1];
        cur_ev_s[EV_WALL0]      = bulletHitWall[0] & ~wall_q[0];
        cur_ev_s[EV_WALL1]      = bulletHitWall[1] & ~wall_q[1];
        cur_ev_s[EV_BULLET]     = bulletHitBullet & ~bb_q;
        cur_ev_s[EV_SPAWN0]     = tankExists[0] & ~exists_q[0];
        cur_ev_s[EV_SPAWN1]     = tankExists[1] & ~exists_q[1];

        snap_s       = acc_q | cur_ev_s;
        acc_d        = acc_q;
        frame_num_d  = frame_num_q;
        score0_d     = score0_q;
        score1_d     = score1_q;
        round_over_d = round_over_q;
        overflow_d   = overflow_q;

        if (frame_edge_s) begin
            // Same-cycle edges go into this snapshot, so the accumulator restarts empty
            acc_d       = '0;
            frame_num_d = frame_num_q + 1'b1;
            if (!round_over_q) begin
                if (snap_s[EV_KILL1] && !snap_s[EV_KILL0]) begin
                    score0_d = score0_q + 1'b1;
                end else if (snap_s[EV_KILL0] && !snap_s[EV_KILL1]) begin
                    score1_d = score1_q + 1'b1;
                end else begin
                    score0_d = score0_q;
                end
                if ((score0_d == WIN_S) || (score1_d == WIN_S)) begin
                    round_over_d          = 1'b1;
                    snap_s[EV_ROUND_OVER] = 1'b1;
                end else begin
                    round_over_d = 1'b0;
                end
            end else begin
                round_over_d = round_over_q;
            end
        end else begin
            acc_d = acc_q | cur_ev_s;
        end

        push_s                 = frame_edge_s & (snap_s != '0);
        push_entry_s.frame_num = frame_num_q;
        push_entry_s.events    = snap_s;

        if (push_s && fifo_full_s && !fifo_pop_ok_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end

        // Clearing takes priority over a coinciding score change
        if (clear_edge_s) begin
            score0_d     = '0;
            score1_d     = '0;
            round_over_d = 1'b0;
            overflow_d   = 1'b0;
        end else begin
            round_over_d = round_over_d;
        end
    end

    // Status word built from the current head and live scores
    always_comb begin
        status_d.valid    = ~fifo_empty_s;
        status_d.overflow = overflow_q;
        status_d.score1   = score1_q;
        status_d.score0   = score0_q;
        if (fifo_empty_s) begin
            status_d.frame_num = '0;
            status_d.events    = '0;
        end else begin
            status_d.frame_num = head_s.frame_num;
            status_d.events    = head_s.events;
        end
    end

    // All reporter state registers
    always_ff @(posedge sysClk or posedge reset_h) begin
        if (reset_h) begin
            kill_q       <= 2'b00;
            exists_q     <= 2'b00;
            wall_q       <= 2'b00;
            bb_q         <= 1'b0;
            ack_q        <= 1'b0;
            clear_q      <= 1'b0;
            fsync1_q     <= 1'b0;
            fsync2_q     <= 1'b0;
            fsync3_q     <= 1'b0;
            acc_q        <= '0;
            frame_num_q  <= '0;
            score0_q     <= '0;
            score1_q     <= '0;
            round_over_q <= 1'b0;
            overflow_q   <= 1'b0;
            status_q     <= '0;
        end else begin
            kill_q       <= kill_d;
            exists_q     <= exists_d;
            wall_q       <= wall_d;
            bb_q         <= bb_d;
            ack_q        <= ack_d;
            clear_q      <= clear_d;
            fsync1_q     <= fsync1_d;
            fsync2_q     <= fsync2_d;
            fsync3_q     <= fsync3_d;
            acc_q        <= acc_d;
            frame_num_q  <= frame_num_d;
            score0_q     <= score0_d;
            score1_q     <= score1_d;
            round_over_q <= round_over_d;
            overflow_q   <= overflow_d;
            status_q     <= status_d;
        end
    end

    status_fifo #(
        .WIDTH ($bits(status_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (sysClk),
        .rst    (reset_h),
        .push   (push_s),
        .pop    (ack_edge_s),
        .wdata  (push_entry_s),
        .rdata  (head_s),
        .full   (fifo_full_s),
        .empty  (fifo_empty_s),
        .pop_ok (fifo_pop_ok_s),
        .count  (fifoCount)
    );

    assign gameStatus = status_q;
    assign roundOver  = round_over_q;

endmodule

// File: tb/tb_game_status_reporter.sv
// Self-checking bench for game_status_reporter: directed scenarios followed
// by randomized frames, all compared against a queue-based game model.
module tb_game_status_reporter;

    localparam int DEPTH = 8;
    localparam int WIN   = 5;

    logic        sysClk = 1'b0;
    logic        reset_h;
    logic        frameClk;
    logic [1:0]  tankKill;
    logic [1:0]  tankExists;
    logic [1:0]  bulletHitWall;
    logic        bulletHitBullet;
    logic        gameAck;
    logic        clearScores;
    logic [31:0] gameStatus;
    logic        roundOver;
    logic [3:0]  fifoCount;

    int checks = 0;
    int passes = 0;

    // Reference model: queue of {frameNum, events} entries plus game state
    logic [21:0] mq[$];
    logic [3:0]  m_s0, m_s1;
    logic        m_ro, m_ovf;
    int          m_frame;
    logic [7:0]  m_acc;

    game_status_reporter #(.FIFO_DEPTH(DEPTH), .WIN_SCORE(WIN)) dut (
        .sysClk          (sysClk),
        .reset_h         (reset_h),
        .frameClk        (frameClk),
        .tankKill        (tankKill),
        .tankExists      (tankExists),
        .bulletHitWall   (bulletHitWall),
        .bulletHitBullet (bulletHitBullet),
        .gameAck         (gameAck),
        .clearScores     (clearScores),
        .gameStatus      (gameStatus),
        .roundOver       (roundOver),
        .fifoCount       (fifoCount)
    );

    always #5 sysClk = ~sysClk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit expired, passed=%0d total=%0d", passes, checks);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        mq.delete();
        m_s0 = 4'd0; m_s1 = 4'd0; m_ro = 1'b0; m_ovf = 1'b0;
        m_frame = 0; m_acc = 8'h00;
    endtask

    // One frame boundary: optional pop first, then scoring and push
    task automatic model_frame(input bit pop);
        logic [7:0] snap;
        if (pop && mq.size() > 0) void'(mq.pop_front());
        snap  = m_acc;
        m_acc = 8'h00;
        if (!m_ro) begin
            if (snap[1] && !snap[0]) m_s0 = m_s0 + 4'd1;
            else if (snap[0] && !snap[1]) m_s1 = m_s1 + 4'd1;
            if (int'(m_s0) == WIN || int'(m_s1) == WIN) begin
                m_ro    = 1'b1;
                snap[7] = 1'b1;
            end
        end
        if (snap != 8'h00) begin
            if (mq.size() < DEPTH) mq.push_back({14'(m_frame), snap});
            else m_ovf = 1'b1;
        end
        m_frame = (m_frame + 1) % 16384;
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_out(input string tag);
        logic [31:0] exp;
        logic [21:0] head;
        head = (mq.size() > 0) ? mq[0] : 22'd0;
        exp  = {(mq.size() > 0), m_ovf, head, m_s1, m_s0};
        check_val({tag, ".status"}, gameStatus, exp);
        check_val({tag, ".roundOver"}, {31'd0, roundOver}, {31'd0, m_ro});
        check_val({tag, ".fifoCount"}, {28'd0, fifoCount}, 32'(mq.size()));
    endtask

    // Drive event levels; model records every rising level as an event
    task automatic drive_ev(input logic [1:0] k, input logic [1:0] e, input logic [1:0] w, input logic b);
        m_acc = m_acc | {1'b0, e & ~tankExists, b & ~bulletHitBullet, w & ~bulletHitWall, k & ~tankKill};
        tankKill = k; tankExists = e; bulletHitWall = w; bulletHitBullet = b;
        @(negedge sysClk);
    endtask

    task automatic do_frame(input bit ack_at_push);
        frameClk = 1'b1;
        @(negedge sysClk);
        @(negedge sysClk);
        if (ack_at_push) gameAck = 1'b1;
        @(negedge sysClk);
        model_frame(ack_at_push);
        gameAck = 1'b0;
        @(negedge sysClk);
        frameClk = 1'b0;
        repeat (3) @(negedge sysClk);
    endtask

    task automatic do_ack();
        gameAck = 1'b1;
        @(negedge sysClk);
        if (mq.size() > 0) void'(mq.pop_front());
        @(negedge sysClk);
        check_out("ack");
        gameAck = 1'b0;
        @(negedge sysClk);
    endtask

    task automatic do_clear();
        clearScores = 1'b1;
        @(negedge sysClk);
        m_s0 = 4'd0; m_s1 = 4'd0; m_ro = 1'b0; m_ovf = 1'b0;
        @(negedge sysClk);
        check_out("clear");
        clearScores = 1'b0;
        @(negedge sysClk);
    endtask

    initial begin
        int r;
        reset_h = 1'b1; frameClk = 1'b0; tankKill = 2'b00; tankExists = 2'b00;
        bulletHitWall = 2'b00; bulletHitBullet = 1'b0; gameAck = 1'b0; clearScores = 1'b0;
        model_reset();
        repeat (3) @(negedge sysClk);
        check_out("reset");
        check_val("reset.zero", gameStatus, 32'h0000_0000);
        reset_h = 1'b0;
        repeat (2) @(negedge sysClk);

        // Three empty frames queue nothing
        for (int i = 0; i < 3; i++) begin
            do_frame(1'b0);
            check_out("empty_frame");
        end

        // Held kill reports once; frameNum 3 seen in the entry
        drive_ev(2'b10, 2'b00, 2'b00, 1'b0);
        do_frame(1'b0);
        check_out("kill1");
        check_val("kill1.word", gameStatus, {1'b1, 1'b0, 14'd3, 8'h02, 4'd0, 4'd1});
        do_frame(1'b0);
        check_out("kill1_held");
        do_ack();
        drive_ev(2'b00, 2'b00, 2'b00, 1'b0);

        // Both kills in one frame: no score change, ack empties the queue
        drive_ev(2'b11, 2'b00, 2'b00, 1'b0);
        drive_ev(2'b00, 2'b00, 2'b00, 1'b0);
        do_frame(1'b0);
        check_out("kill_both");
        check_val("kill_both.events", {24'd0, gameStatus[15:8]}, 32'h03);
        do_ack();
        check_val("kill_both.valid", {31'd0, gameStatus[31]}, 32'd0);

        // Reach WIN_SCORE, then scores freeze until cleared
        do_clear();
        for (int i = 0; i < 6; i++) begin
            drive_ev(2'b10, 2'b00, 2'b00, 1'b0);
            drive_ev(2'b00, 2'b00, 2'b00, 1'b0);
            do_frame(1'b0);
            check_out("win");
            if (i == 4) check_val("win.word", {16'd0, gameStatus[15:0]}, {16'd0, 8'h82, 4'd0, 4'd5});
            if (i == 5) check_val("frozen.word", {16'd0, gameStatus[15:0]}, {16'd0, 8'h02, 4'd0, 4'd5});
            do_ack();
        end
        do_clear();
        check_val("cleared.ro", {31'd0, roundOver}, 32'd0);

        // Overflow: ninth push dropped
        for (int i = 0; i < 9; i++) begin
            drive_ev(2'b00, 2'b00, 2'b00, 1'b1);
            drive_ev(2'b00, 2'b00, 2'b00, 1'b0);
            do_frame(1'b0);
            check_out("fill");
        end
        check_val("ovf.count", {28'd0, fifoCount}, 32'd8);
        check_val("ovf.flag", {31'd0, gameStatus[30]}, 32'd1);
        for (int i = 0; i < 8; i++) do_ack();
        do_clear();

        // Full FIFO with a pop on the push cycle: ninth push accepted
        for (int i = 0; i < 9; i++) begin
            drive_ev(2'b00, 2'b00, 2'b00, 1'b1);
            drive_ev(2'b00, 2'b00, 2'b00, 1'b0);
            do_frame(i == 8);
            check_out("fill_pop");
        end
        check_val("nopovf.count", {28'd0, fifoCount}, 32'd8);
        check_val("nopovf.flag", {31'd0, gameStatus[30]}, 32'd0);
        for (int i = 0; i < 8; i++) do_ack();

        // Wall hit rising exactly on the frameEdge cycle
        frameClk = 1'b1;
        @(negedge sysClk);
        @(negedge sysClk);
        drive_ev(2'b00, 2'b00, 2'b01, 1'b0);
        model_frame(1'b0);
        @(negedge sysClk);
        frameClk = 1'b0;
        repeat (3) @(negedge sysClk);
        check_out("wall_edge");
        check_val("wall_edge.events", {24'd0, gameStatus[15:8]}, 32'h04);
        drive_ev(2'b00, 2'b00, 2'b00, 1'b0);
        do_frame(1'b0);
        check_out("wall_next");
        check_val("wall_next.count", {28'd0, fifoCount}, 32'd1);

        // Asynchronous reset mid-frame
        frameClk = 1'b1;
        @(negedge sysClk);
        #2 reset_h = 1'b1;
        #1;
        model_reset();
        check_out("async_reset");
        check_val("async_reset.zero", gameStatus, 32'h0000_0000);
        frameClk = 1'b0; tankKill = 2'b00; tankExists = 2'b00;
        bulletHitWall = 2'b00; bulletHitBullet = 1'b0;
        repeat (3) @(negedge sysClk);
        reset_h = 1'b0;
        repeat (2) @(negedge sysClk);

        // Randomized frames, acks and clears
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            drive_ev(2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom));
            if (r < 3) drive_ev(2'b00, tankExists, 2'b00, 1'b0);
            if (r == 9) do_clear();
            do_frame(r == 4 || r == 5);
            check_out("rand_frame");
            if (r < 6) do_ack();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/game_status_reporter.md
Name: game_status_reporter

Overview:
- Hardware→software half of the game PIO link, the counterpart of the tank_control path. Collects per-frame game events (kills, spawns, wall/bullet hits) and queues them for the NIOS II via the game_status PIO.
- Keeps per-tank scores and flags round over.
- Software reads gameStatus, then pulses gameAck to pop the next entry.
- Lives in the top level next to the collision logic, on the CLOCK_50 domain.

Parameters:
FIFO_DEPTH, 8, event-entry queue depth (power of 2, min 2)
WIN_SCORE, 5, score that ends a round (1..15)

Ports:
sysClk  in  1  system clock (CLOCK_50)
reset_h  in  1  asynchronous active-high reset
frameClk  in  1  VGA_VS level; sampled as data, never used as a clock
tankKill  in  2  per-tank kill level
tankExists  in  2  per-tank exists level
bulletHitWall  in  2  per-bullet wall-hit level
bulletHitBullet  in  1  bullet-bullet collision level
gameAck  in  1  PIO level from software; rising edge pops the head entry
clearScores  in  1  PIO level; rising edge clears scores, round-over and overflow
gameStatus  out  32  {valid, overflow, frameNum[13:0], events[7:0], score1[3:0], score0[3:0]}
roundOver  out  1  a score has reached WIN_SCORE
fifoCount  out  $clog2(FIFO_DEPTH)+1  occupied entries

Behaviour:
- Reset (async, reset_h=1): FIFO empty, all scores 0, frameNum 0, accumulator 0, overflow 0, roundOver 0, gameStatus 0, all edge/sync flops 0.
- Event bit map:
  - bit0 tank0 killed, bit1 tank1 killed
  - bit2 bullet0 hit wall, bit3 bullet1 hit wall
  - bit4 bullet-bullet
  - bit5 tank0 spawned (tankExists[0] rise), bit6 tank1 spawned
  - bit7 round ended this frame
- Event inputs: register each once, rising-edge detect in sysClk.
  - Each edge ORs into an 8-bit accumulator.
  - A level held high reports only once.
- Frame detection:
  - frameClk passes a 2-flop synchronizer plus 1 history flop.
  - frameEdge = sync2 & ~sync3, true on the 3rd sysClk edge after frameClk rises.
- On a frameEdge cycle:
  - Capture snapshot = accumulator | edges in this cycle. The accumulator reloads with 0, so no same-cycle event is lost or double counted.
  - frameNum increments, wrapping 16383→0.
  - Score update uses the snapshot, only if roundOver=0:
    - bit1 only set: score0+1.
    - bit0 only set: score1+1.
    - both set: no change.
    - When a new score equals WIN_SCORE: roundOver←1 and snapshot bit7 set. Scores then freeze until clearScores.
  - Push: if snapshot≠0, push {frameNum (pre-increment), snapshot}.
- FIFO full:
  - Push is dropped and overflow←1 (sticky).
  - Exception: a pop in the same cycle frees the slot, so the push succeeds and overflow is unchanged.
- gameAck rising edge (registered edge detect, same clock domain, no sync):
  - Pops when non-empty.
  - Ignored when empty, with no underflow and count unchanged.
- clearScores rising edge: scores, roundOver and overflow ←0. FIFO contents are kept.
- clearScores coinciding with a scoring frame: clear wins; that frame's score change is discarded, but the entry is still pushed.
- gameStatus is a registered output, updated one cycle after any FIFO/score change:
  - valid = FIFO non-empty.
  - frameNum/events come from the head entry, or 0 when empty.
  - Scores are live values.
- Latency:
  - frameClk rise → push on sysClk edge 3 → gameStatus valid after edge 4.
  - gameAck rise → pop on edge 1 → gameStatus shows the next head after edge 2.
- Reset mid-operation: everything returns to reset values immediately; queued entries are lost.

Decomposition:
- Shared game types package holds:
  - GAME_EVENT bit-index constants (EV_KILL0..EV_ROUND_OVER).
  - Packed STATUS_WORD struct matching the gameStatus layout.
  - STATUS_ENTRY struct {frameNum, events}.
- One sub-module, status_fifo: synchronous FIFO, async reset, parameterized width/depth.
  - Signals: push/pop/full/empty/count, plus same-cycle push+pop when full.
  - Head visible combinationally.

Test Plan:
- Reset, then 3 frameClk pulses with no events → gameStatus=0, fifoCount=0. Internal frameNum reaches 3; checked via the next entry reporting frameNum=3.
- tankKill[1] held high across 2 frames → exactly one entry, events=0x02, score0=1. Second frame pushes nothing.
- tankKill[0] and tankKill[1] rise in the same frame → events=0x03, scores unchanged. Then pulse gameAck → valid=0 two cycles later.
- Kill tank1 five times in separate frames (WIN_SCORE=5) → 5th entry events=0x82, score0=5, roundOver=1. A 6th kill gives events=0x02 with score0 still 5. clearScores rise → scores 0, roundOver 0.
- Nine event frames without ack (FIFO_DEPTH=8) → fifoCount=8, overflow=1, 9th dropped. Repeat with gameAck rising on the push cycle → 9th accepted, overflow=0.
- bulletHitWall[0] rises on the exact frameEdge cycle → reported in that frame's entry (events=0x04), not repeated in the next frame. Also assert reset_h mid-frame → all outputs 0 asynchronously.
